// File: rtl/alu_issue_if.sv
// ALU operation interface: decoded op + operands
// flowing from the issue stage into the ALU.
interface alu_issue_if;
    logic        valid;
    logic        ready;
    logic [12:0] op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;

    modport master (
        output valid,
        output op,
        output in1,
        output in2,
        output rd,
        output we,
        output illegal,
        input  ready
    );

    modport slave (
        input  valid,
        input  op,
        input  in1,
        input  in2,
        input  rd,
        input  we,
        input  illegal,
        output ready
    );
endinterface

// File: rtl/alu_issue.sv
// RV32IM decode/issue stage: one registered slot that
// turns an instruction + operands into a one-hot ALU op.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    alu_issue_if.master alu
);

    localparam logic [12:0] OP_ADD  = 13'h0001;
    localparam logic [12:0] OP_SUB  = 13'h0002;
    localparam logic [12:0] OP_XOR  = 13'h0004;
    localparam logic [12:0] OP_OR   = 13'h0008;
    localparam logic [12:0] OP_AND  = 13'h0010;
    localparam logic [12:0] OP_SLL  = 13'h0020;
    localparam logic [12:0] OP_SRL  = 13'h0040;
    localparam logic [12:0] OP_SRA  = 13'h0080;
    localparam logic [12:0] OP_SLT  = 13'h0100;
    localparam logic [12:0] OP_SLTU = 13'h0200;
    localparam logic [12:0] OP_MUL  = 13'h0400;
    localparam logic [12:0] OP_DIV  = 13'h0800;
    localparam logic [12:0] OP_REM  = 13'h1000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    // funct3 mapping shared by OP and OP-IMM
    function automatic logic [12:0] base_op(
        input logic [2:0] f3
    );
        logic [12:0] r;
        unique case (f3)
            3'b000:  r = OP_ADD;
            3'b001:  r = OP_SLL;
            3'b010:  r = OP_SLT;
            3'b011:  r = OP_SLTU;
            3'b100:  r = OP_XOR;
            3'b101:  r = OP_SRL;
            3'b110:  r = OP_OR;
            default: r = OP_AND;
        endcase
        return r;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        unused_rs1_field;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rd_f   = in_inst[11:7];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}},
                     in_inst[31:25], in_inst[11:7]};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign shamt  = {27'b0, in_inst[24:20]};
    assign unused_rs1_field = ^in_inst[19:15];

    logic is_op;
    logic is_opimm;
    logic is_lui;
    logic is_auipc;
    logic is_load;
    logic is_store;

    assign is_op    = (opcode == 7'b0110011);
    assign is_opimm = (opcode == 7'b0010011);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_auipc = (opcode == 7'b0010111);
    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);

    logic [12:0] dec_op;
    logic [31:0] dec_in1;
    logic [31:0] dec_in2;
    logic [4:0]  dec_rd;
    logic        dec_we;
    logic        dec_ill;

    always_comb begin
        dec_op  = 13'b0;
        dec_in1 = 32'b0;
        dec_in2 = 32'b0;
        dec_rd  = rd_f;
        dec_we  = (rd_f != 5'd0);
        dec_ill = 1'b0;
        unique case (1'b1)
            is_op: begin
                dec_in1 = in_rs1_val;
                dec_in2 = in_rs2_val;
                if (f7 == F7_BASE) begin
                    dec_op = base_op(f3);
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)
                        dec_op = OP_SUB;
                    else if (f3 == 3'b101)
                        dec_op = OP_SRA;
                    else
                        dec_ill = 1'b1;
                end else if (f7 == F7_MULD) begin
                    if (f3 == 3'b000)
                        dec_op = OP_MUL;
                    else if (f3 == 3'b100)
                        dec_op = OP_DIV;
                    else if (f3 == 3'b110)
                        dec_op = OP_REM;
                    else
                        dec_ill = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            is_opimm: begin
                dec_in1 = in_rs1_val;
                dec_in2 = imm_i;
                dec_op  = base_op(f3);
                // shifts take shamt and police funct7
                if (f3 == 3'b001) begin
                    dec_in2 = shamt;
                    if (f7 != F7_BASE)
                        dec_ill = 1'b1;
                end else if (f3 == 3'b101) begin
                    dec_in2 = shamt;
                    if (f7 == F7_ALT)
                        dec_op = OP_SRA;
                    else if (f7 != F7_BASE)
                        dec_ill = 1'b1;
                end
            end
            is_lui: begin
                dec_op  = OP_ADD;
                dec_in2 = imm_u;
            end
            is_auipc: begin
                dec_op  = OP_ADD;
                dec_in1 = in_pc;
                dec_in2 = imm_u;
            end
            is_load: begin
                dec_op  = OP_ADD;
                dec_in1 = in_rs1_val;
                dec_in2 = imm_i;
            end
            is_store: begin
                dec_op  = OP_ADD;
                dec_in1 = in_rs1_val;
                dec_in2 = imm_s;
                dec_rd  = 5'd0;
                dec_we  = 1'b0;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_op  = 13'b0;
            dec_in1 = 32'b0;
            dec_in2 = 32'b0;
            dec_rd  = rd_f;
            dec_we  = 1'b0;
        end
    end

    logic        valid_q, valid_d;
    logic [12:0] op_q, op_d;
    logic [31:0] in1_q, in1_d;
    logic [31:0] in2_q, in2_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic        ill_q, ill_d;
    logic        accept;

    assign in_ready = !valid_q || alu.ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        rd_d    = rd_q;
        we_d    = we_q;
        ill_d   = ill_q;
        if (flush) begin
            valid_d = 1'b0;
            op_d    = 13'b0;
            in1_d   = 32'b0;
            in2_d   = 32'b0;
            rd_d    = 5'd0;
            we_d    = 1'b0;
            ill_d   = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            op_d    = dec_op;
            in1_d   = dec_in1;
            in2_d   = dec_in2;
            rd_d    = dec_rd;
            we_d    = dec_we;
            ill_d   = dec_ill;
        end else if (valid_q && alu.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= 13'b0;
            in1_q   <= 32'b0;
            in2_q   <= 32'b0;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
        end
    end

    assign alu.valid   = valid_q;
    assign alu.op      = op_q;
    assign alu.in1     = in1_q;
    assign alu.in2     = in2_q;
    assign alu.rd      = rd_q;
    assign alu.we      = we_q;
    assign alu.illegal = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed vector bench for alu_issue: decode table
// plus stall, flush and reset sequences.
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;

    alu_issue_if aif ();

    alu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .alu        (aif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [12:0] op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic add(
        input string       nm,
        input logic [31:0] inst,
        input logic [31:0] pc,
        input logic [31:0] rs1,
        input logic [31:0] rs2,
        input logic [12:0] op,
        input logic [31:0] in1,
        input logic [31:0] in2,
        input logic [4:0]  rd,
        input logic        we,
        input logic        ill
    );
        vec_t v;
        v.name = nm;
        v.inst = inst;
        v.pc   = pc;
        v.rs1  = rs1;
        v.rs2  = rs2;
        v.op   = op;
        v.in1  = in1;
        v.in2  = in2;
        v.rd   = rd;
        v.we   = we;
        v.ill  = ill;
        vecs.push_back(v);
    endtask

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h",
                     nm, act, exp);
        end
    endtask

    task automatic chk_out(
        input string       nm,
        input logic        v,
        input logic [12:0] op,
        input logic [31:0] in1,
        input logic [31:0] in2,
        input logic [4:0]  rd,
        input logic        we,
        input logic        ill
    );
        chk({nm, ".valid"}, 32'(aif.valid), 32'(v));
        chk({nm, ".op"}, 32'(aif.op), 32'(op));
        chk({nm, ".in1"}, aif.in1, in1);
        chk({nm, ".in2"}, aif.in2, in2);
        chk({nm, ".rd"}, 32'(aif.rd), 32'(rd));
        chk({nm, ".we"}, 32'(aif.we), 32'(we));
        chk({nm, ".ill"}, 32'(aif.illegal), 32'(ill));
    endtask

    task automatic drive(
        input logic [31:0] inst,
        input logic [31:0] pc,
        input logic [31:0] rs1,
        input logic [31:0] rs2
    );
        in_valid   = 1'b1;
        in_inst    = inst;
        in_pc      = pc;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_inst    = 32'h0;
        in_pc      = 32'h0;
        in_rs1_val = 32'h0;
        in_rs2_val = 32'h0;
        aif.ready  = 1'b1;

        add("addi", 32'hFFF08293, 0, 10, 0,
            13'h0001, 10, 32'hFFFFFFFF, 5, 1, 0);
        add("sub", 32'h402081B3, 0, 7, 9,
            13'h0002, 7, 9, 3, 1, 0);
        add("srai", 32'h40315093, 0, 32'h80000000, 0,
            13'h0080, 32'h80000000, 3, 1, 1, 0);
        add("srli", 32'h00315093, 0, 32'h80000000, 0,
            13'h0040, 32'h80000000, 3, 1, 1, 0);
        add("divu", 32'h0220D0B3, 0, 4, 5,
            13'h0000, 0, 0, 1, 0, 1);
        add("beq", 32'h00208463, 0, 4, 5,
            13'h0000, 0, 0, 8, 0, 1);
        add("add", 32'h002081B3, 0, 5, 6,
            13'h0001, 5, 6, 3, 1, 0);
        add("xor", 32'h0020C1B3, 0, 5, 6,
            13'h0004, 5, 6, 3, 1, 0);
        add("or", 32'h0020E1B3, 0, 5, 6,
            13'h0008, 5, 6, 3, 1, 0);
        add("and", 32'h0020F1B3, 0, 5, 6,
            13'h0010, 5, 6, 3, 1, 0);
        add("sll", 32'h002091B3, 0, 5, 6,
            13'h0020, 5, 6, 3, 1, 0);
        add("srl", 32'h0020D1B3, 0, 5, 6,
            13'h0040, 5, 6, 3, 1, 0);
        add("sra", 32'h4020D1B3, 0, 5, 6,
            13'h0080, 5, 6, 3, 1, 0);
        add("slt", 32'h0020A1B3, 0, 5, 6,
            13'h0100, 5, 6, 3, 1, 0);
        add("sltu", 32'h0020B1B3, 0, 5, 6,
            13'h0200, 5, 6, 3, 1, 0);
        add("mul", 32'h022081B3, 0, 5, 6,
            13'h0400, 5, 6, 3, 1, 0);
        add("div", 32'h0220C1B3, 0, 5, 6,
            13'h0800, 5, 6, 3, 1, 0);
        add("rem", 32'h0220E1B3, 0, 5, 6,
            13'h1000, 5, 6, 3, 1, 0);
        add("mulh", 32'h022091B3, 0, 5, 6,
            13'h0000, 0, 0, 3, 0, 1);
        add("alt_sll", 32'h402091B3, 0, 5, 6,
            13'h0000, 0, 0, 3, 0, 1);
        add("slli_bad", 32'h40311093, 0, 5, 6,
            13'h0000, 0, 0, 1, 0, 1);
        add("xori", 32'h0F00C313, 0, 5, 6,
            13'h0004, 5, 32'h000000F0, 6, 1, 0);
        add("sltiu", 32'hFFF0B313, 0, 5, 6,
            13'h0200, 5, 32'hFFFFFFFF, 6, 1, 0);
        add("addi_x0", 32'h00100013, 0, 9, 6,
            13'h0001, 9, 1, 0, 0, 0);
        add("lui", 32'h123453B7, 0, 32'hDEAD, 6,
            13'h0001, 0, 32'h12345000, 7, 1, 0);
        add("auipc", 32'h00001397, 32'h100, 3, 6,
            13'h0001, 32'h100, 32'h1000, 7, 1, 0);
        add("lw", 32'hFFC12203, 0, 32'h1000, 6,
            13'h0001, 32'h1000, 32'hFFFFFFFC, 4, 1, 0);
        add("sw", 32'h0020A423, 0, 32'h2000, 6,
            13'h0001, 32'h2000, 8, 0, 0, 0);
        add("sw_neg", 32'hFE20AE23, 0, 32'h2000, 6,
            13'h0001, 32'h2000, 32'hFFFFFFFC, 0, 0, 0);

        step();
        step();
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("reset.in_ready", 32'(in_ready), 1);

        // back-to-back vectors at full rate
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].inst, vecs[i].pc,
                  vecs[i].rs1, vecs[i].rs2);
            step();
            chk_out(vecs[i].name, 1, vecs[i].op,
                    vecs[i].in1, vecs[i].in2,
                    vecs[i].rd, vecs[i].we, vecs[i].ill);
        end
        in_valid = 1'b0;
        step();
        chk("drain.valid", 32'(aif.valid), 0);

        // stall: A held for 3 cycles while B waits
        aif.ready = 1'b0;
        drive(32'h002081B3, 0, 11, 22);
        step();
        drive(32'h402081B3, 0, 7, 9);
        for (int c = 0; c < 3; c++) begin
            chk("stall.in_ready", 32'(in_ready), 0);
            chk_out("stall.hold", 1, 13'h0001,
                    11, 22, 3, 1, 0);
            step();
        end
        aif.ready = 1'b1;
        #1;
        chk("stall.release", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk_out("stall.b", 1, 13'h0002, 7, 9, 3, 1, 0);
        step();
        chk("stall.nodup", 32'(aif.valid), 0);

        // flush while A held and B offered
        aif.ready = 1'b0;
        drive(32'h002081B3, 0, 11, 22);
        step();
        chk("flush.pre", 32'(aif.valid), 1);
        drive(32'h402081B3, 0, 7, 9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk_out("flush", 0, 0, 0, 0, 0, 0, 0);
        aif.ready = 1'b1;
        step();
        chk("flush.no_b", 32'(aif.valid), 0);

        // flush coinciding with a consumer transfer
        drive(32'hFFF08293, 0, 10, 0);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_xfer.valid", 32'(aif.valid), 0);
        step();
        chk("flush_xfer.norepeat", 32'(aif.valid), 0);

        // reset pulse with an entry held
        aif.ready = 1'b0;
        drive(32'h123453B7, 0, 0, 0);
        step();
        chk("rst.pre", 32'(aif.valid), 1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_mid.in_ready", 32'(in_ready), 1);

        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule
